tse_xcvr_reset_sequencer: RTL and testbench
===========================================

Name: tse_xcvr_reset_sequencer

Overview:
- Consumes transceiver status bits after the two-flop resync stage and drives the TSE transceiver reset/powerdown controls in the required order.
- Contains two independent state machines, one for TX and one for RX, each with dwell counters.
- Reports tx_ready and rx_ready to the MAC/PCS wrapper.
- All inputs except clr_n are synchronous to clk; the block adds no synchronizers of its own.

Parameters:
- PLL_PD_CYCLES, 16: cycles pll_powerdown stays high after reset release or restart.
- TX_DIG_CYCLES, 8: cycles pll_locked must stay stable before tx_digitalreset releases.
- RX_LTD_CYCLES, 32: cycles rx_is_lockedtodata must stay stable before rx_digitalreset releases.
- CNT_W, 16: dwell counter width. Must satisfy 2^CNT_W > max(all cycle parameters).

Ports:
- clk  in  1  system clock.
- clr_n  in  1  asynchronous active-low reset.
- tx_reset_req  in  1  synchronous restart request for TX (level or pulse).
- rx_reset_req  in  1  synchronous restart request for RX.
- pll_locked  in  1  TX PLL lock, already resynchronized.
- tx_cal_busy  in  1  TX calibration in progress, resynchronized.
- rx_cal_busy  in  1  RX calibration in progress, resynchronized.
- rx_is_lockedtodata  in  1  CDR data lock, resynchronized.
- pll_powerdown  out  1  TX PLL powerdown.
- tx_analogreset  out  1  TX PMA reset.
- tx_digitalreset  out  1  TX PCS reset.
- rx_analogreset  out  1  RX PMA reset.
- rx_digitalreset  out  1  RX PCS reset.
- tx_ready  out  1  TX path out of reset.
- rx_ready  out  1  RX path out of reset.

Behaviour:
- Reset: clk, clr_n asynchronous active-low. While clr_n=0:
  - pll_powerdown, tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset = 1.
  - tx_ready, rx_ready = 0.
  - Both FSMs in their first state; counters = 0.
- All outputs are registered and decoded from the state registers. An output changes in the cycle after the state change that causes it.
- TX FSM:
  - TX_PD: pll_powerdown=1, tx_analogreset=1, tx_digitalreset=1. Counter increments each cycle. Leave when counter = PLL_PD_CYCLES-1, so the state lasts exactly PLL_PD_CYCLES cycles.
  - TX_ANA: pll_powerdown=0, tx_analogreset=1, tx_digitalreset=1. Leave when tx_cal_busy=0.
  - TX_LOCK: tx_analogreset=0, tx_digitalreset=1.
    - Counter clears whenever pll_locked=0.
    - Leave when pll_locked=1 for TX_DIG_CYCLES consecutive cycles.
  - TX_RDY: tx_digitalreset=0, tx_ready=1.
  - pll_locked=0 in TX_RDY: go to TX_LOCK, clear counter. tx_digitalreset=1 and tx_ready=0 from the next cycle.
  - tx_cal_busy=1 in TX_LOCK or TX_RDY: go to TX_ANA.
- RX FSM:
  - RX_ANA: rx_analogreset=1, rx_digitalreset=1. Leave when rx_cal_busy=0 and the TX FSM is in TX_LOCK or TX_RDY (PLL powered).
  - RX_LTD: rx_analogreset=0, rx_digitalreset=1.
    - Counter clears when rx_is_lockedtodata=0.
    - Leave after RX_LTD_CYCLES consecutive cycles with rx_is_lockedtodata=1.
  - RX_RDY: rx_digitalreset=0, rx_ready=1.
  - rx_is_lockedtodata=0 in RX_RDY: go to RX_LTD. rx_cal_busy=1 in RX_LTD or RX_RDY: go to RX_ANA.
- Restart requests:
  - tx_reset_req=1: TX FSM goes to TX_PD and its counter clears. While the request is held, the FSM stays in TX_PD with the counter held at 0.
  - A TX restart also forces the RX FSM to RX_ANA.
  - rx_reset_req=1: only the RX FSM goes to RX_ANA.
  - A restart request wins over every other transition in the same cycle.
- Simultaneous events: lock loss and calibration busy in the same cycle selects the earlier state (ANA).
- Counters saturate and never wrap.
- clr_n assertion mid-sequence immediately forces all outputs to their reset values.

Optional Feature:
- Macro: TSE_XCVR_RST_LOL_CNT_EN.
- When defined:
  - Adds output port rx_lol_count [7:0], reset to 0.
  - Increments by 1 each time the RX FSM leaves RX_RDY because rx_is_lockedtodata=0.
  - Saturates at 255.
  - Cleared by rx_reset_req=1 and by clr_n.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Basic bring-up: clr_n released at cycle 0, cal_busy=0, pll_locked=1, lockedtodata=1 -> pll_powerdown falls after exactly 16 cycles, tx_ready=1 about 9 cycles later, rx_ready=1 about 33 cycles after RX_LTD entry.
- Calibration stall: tx_cal_busy=1 held for 100 cycles after TX_PD -> tx_analogreset stays 1 until tx_cal_busy falls; rx_analogreset stays 1 throughout.
- PLL lock glitch: pll_locked low for 1 cycle in TX_RDY -> tx_ready=0 and tx_digitalreset=1 next cycle; tx_ready returns after 8 stable cycles; RX unaffected.
- CDR lock bouncing: rx_is_lockedtodata toggles every 5 cycles in RX_LTD -> rx_ready never asserts; then held high -> rx_ready=1 after 32 cycles.
- Restart priority: tx_reset_req pulsed in the same cycle as pll_locked loss in TX_RDY -> TX_PD entered, pll_powerdown=1 for 16 cycles, rx_ready=0.
- With TSE_XCVR_RST_LOL_CNT_EN: 300 lock-loss events from RX_RDY -> rx_lol_count=255; rx_reset_req -> rx_lol_count=0.

Source files
------------

// File: rtl/tse_xcvr_reset_sequencer_if.sv
// Control/status bundle between the transceiver reset sequencer and its surroundings.
// The sequencer takes the slave modport; the MAC/PCS wrapper side takes master.
interface tse_xcvr_reset_sequencer_if;
  logic tx_reset_req;
  logic rx_reset_req;
  logic pll_locked;
  logic tx_cal_busy;
  logic rx_cal_busy;
  logic rx_is_lockedtodata;
  logic pll_powerdown;
  logic tx_analogreset;
  logic tx_digitalreset;
  logic rx_analogreset;
  logic rx_digitalreset;
  logic tx_ready;
  logic rx_ready;

  modport master (
    output tx_reset_req, rx_reset_req, pll_locked, tx_cal_busy, rx_cal_busy,
           rx_is_lockedtodata,
    input  pll_powerdown, tx_analogreset, tx_digitalreset, rx_analogreset,
           rx_digitalreset, tx_ready, rx_ready
  );

  modport slave (
    input  tx_reset_req, rx_reset_req, pll_locked, tx_cal_busy, rx_cal_busy,
           rx_is_lockedtodata,
    output pll_powerdown, tx_analogreset, tx_digitalreset, rx_analogreset,
           rx_digitalreset, tx_ready, rx_ready
  );
endinterface

// File: rtl/tse_xcvr_reset_sequencer.sv
// TSE transceiver reset sequencer: independent TX and RX FSMs with dwell counters.
// Optional RX loss-of-lock event counter enabled by defining TSE_XCVR_RST_LOL_CNT_EN.
module tse_xcvr_reset_sequencer #(
  parameter int unsigned PLL_PD_CYCLES = 16,
  parameter int unsigned TX_DIG_CYCLES = 8,
  parameter int unsigned RX_LTD_CYCLES = 32,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                          clk,
  input  logic                          clr_n,
  tse_xcvr_reset_sequencer_if.slave     xcvr
`ifdef TSE_XCVR_RST_LOL_CNT_EN
  ,
  output logic [7:0]                    rx_lol_count
`endif
);

  typedef enum logic [1:0] {TxPd, TxAna, TxLock, TxRdy} tx_state_e;
  typedef enum logic [1:0] {RxAna, RxLtd, RxRdy} rx_state_e;

  tx_state_e        tx_state_q;
  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] tx_cnt_q, rx_cnt_q;
  logic [CNT_W-1:0] tx_cnt_inc, rx_cnt_inc;
  logic             pll_powerdown_q, tx_analogreset_q, tx_digitalreset_q, tx_ready_q;
  logic             rx_analogreset_q, rx_digitalreset_q, rx_ready_q;
  logic             tx_pll_up;

  // Saturating increments so a dwell counter can never wrap back to zero.
  assign tx_cnt_inc = (tx_cnt_q == {CNT_W{1'b1}}) ? tx_cnt_q : tx_cnt_q + 1'b1;
  assign rx_cnt_inc = (rx_cnt_q == {CNT_W{1'b1}}) ? rx_cnt_q : rx_cnt_q + 1'b1;
  assign tx_pll_up  = (tx_state_q == TxLock) || (tx_state_q == TxRdy);

  // TX FSM; outputs are decoded from the present state, so they lag a transition by one cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tx_state_q        <= TxPd;
      tx_cnt_q          <= '0;
      pll_powerdown_q   <= 1'b1;
      tx_analogreset_q  <= 1'b1;
      tx_digitalreset_q <= 1'b1;
      tx_ready_q        <= 1'b0;
    end else begin
      pll_powerdown_q   <= (tx_state_q == TxPd);
      tx_analogreset_q  <= (tx_state_q == TxPd) || (tx_state_q == TxAna);
      tx_digitalreset_q <= (tx_state_q != TxRdy);
      tx_ready_q        <= (tx_state_q == TxRdy);
      if (xcvr.tx_reset_req) begin
        tx_state_q <= TxPd;
        tx_cnt_q   <= '0;
      end else begin
        unique case (tx_state_q)
          TxPd: begin
            if (tx_cnt_q == CNT_W'(PLL_PD_CYCLES - 1)) begin
              tx_state_q <= TxAna;
              tx_cnt_q   <= '0;
            end else begin
              tx_cnt_q <= tx_cnt_inc;
            end
          end
          TxAna: begin
            if (!xcvr.tx_cal_busy) begin
              tx_state_q <= TxLock;
              tx_cnt_q   <= '0;
            end
          end
          TxLock: begin
            if (xcvr.tx_cal_busy) begin
              tx_state_q <= TxAna;
              tx_cnt_q   <= '0;
            end else if (!xcvr.pll_locked) begin
              tx_cnt_q <= '0;
            end else if (tx_cnt_q == CNT_W'(TX_DIG_CYCLES - 1)) begin
              tx_state_q <= TxRdy;
              tx_cnt_q   <= '0;
            end else begin
              tx_cnt_q <= tx_cnt_inc;
            end
          end
          TxRdy: begin
            // Calibration wins over lock loss: fall back to the earlier state.
            if (xcvr.tx_cal_busy) begin
              tx_state_q <= TxAna;
              tx_cnt_q   <= '0;
            end else if (!xcvr.pll_locked) begin
              tx_state_q <= TxLock;
              tx_cnt_q   <= '0;
            end
          end
        endcase
      end
    end
  end

  // RX FSM; a TX restart also drags RX back to analog reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rx_state_q        <= RxAna;
      rx_cnt_q          <= '0;
      rx_analogreset_q  <= 1'b1;
      rx_digitalreset_q <= 1'b1;
      rx_ready_q        <= 1'b0;
    end else begin
      rx_analogreset_q  <= (rx_state_q == RxAna);
      rx_digitalreset_q <= (rx_state_q != RxRdy);
      rx_ready_q        <= (rx_state_q == RxRdy);
      if (xcvr.tx_reset_req || xcvr.rx_reset_req) begin
        rx_state_q <= RxAna;
        rx_cnt_q   <= '0;
      end else begin
        unique case (rx_state_q)
          RxAna: begin
            if (!xcvr.rx_cal_busy && tx_pll_up) begin
              rx_state_q <= RxLtd;
              rx_cnt_q   <= '0;
            end
          end
          RxLtd: begin
            if (xcvr.rx_cal_busy) begin
              rx_state_q <= RxAna;
              rx_cnt_q   <= '0;
            end else if (!xcvr.rx_is_lockedtodata) begin
              rx_cnt_q <= '0;
            end else if (rx_cnt_q == CNT_W'(RX_LTD_CYCLES - 1)) begin
              rx_state_q <= RxRdy;
              rx_cnt_q   <= '0;
            end else begin
              rx_cnt_q <= rx_cnt_inc;
            end
          end
          RxRdy: begin
            if (xcvr.rx_cal_busy) begin
              rx_state_q <= RxAna;
              rx_cnt_q   <= '0;
            end else if (!xcvr.rx_is_lockedtodata) begin
              rx_state_q <= RxLtd;
              rx_cnt_q   <= '0;
            end
          end
          default: begin
            rx_state_q <= RxAna;
            rx_cnt_q   <= '0;
          end
        endcase
      end
    end
  end

`ifdef TSE_XCVR_RST_LOL_CNT_EN
  logic [7:0] lol_cnt_q;

  // Counts only RX_RDY exits caused by CDR lock loss, not restarts or calibration.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      lol_cnt_q <= '0;
    end else if (xcvr.rx_reset_req) begin
      lol_cnt_q <= '0;
    end else if (!xcvr.tx_reset_req && (rx_state_q == RxRdy) && !xcvr.rx_cal_busy &&
                 !xcvr.rx_is_lockedtodata && (lol_cnt_q != 8'hff)) begin
      lol_cnt_q <= lol_cnt_q + 8'd1;
    end
  end

  assign rx_lol_count = lol_cnt_q;
`endif

  assign xcvr.pll_powerdown   = pll_powerdown_q;
  assign xcvr.tx_analogreset  = tx_analogreset_q;
  assign xcvr.tx_digitalreset = tx_digitalreset_q;
  assign xcvr.tx_ready        = tx_ready_q;
  assign xcvr.rx_analogreset  = rx_analogreset_q;
  assign xcvr.rx_digitalreset = rx_digitalreset_q;
  assign xcvr.rx_ready        = rx_ready_q;

endmodule

// File: tb/tb_tse_xcvr_reset_sequencer.sv
// Directed bench for tse_xcvr_reset_sequencer; the TSE_XCVR_RST_LOL_CNT_EN build adds a
// loss-of-lock counter scenario.
module tb_tse_xcvr_reset_sequencer;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  tse_xcvr_reset_sequencer_if xif ();
  logic [6:0] outs;
  assign outs = {xif.pll_powerdown, xif.tx_analogreset, xif.tx_digitalreset,
                 xif.rx_analogreset, xif.rx_digitalreset, xif.tx_ready, xif.rx_ready};

`ifdef TSE_XCVR_RST_LOL_CNT_EN
  logic [7:0] rx_lol_count;
  tse_xcvr_reset_sequencer dut (.clk(clk), .clr_n(clr_n), .xcvr(xif),
                                .rx_lol_count(rx_lol_count));
`else
  tse_xcvr_reset_sequencer dut (.clk(clk), .clr_n(clr_n), .xcvr(xif));
`endif

  always #5 clk = ~clk;

  // Advance one active edge, then settle before driving or sampling.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Fresh reset; the next posedge after this task is edge 1 of the sequence.
  task automatic restart(input logic tx_cal);
    clr_n = 1'b0;
    xif.tx_reset_req = 1'b0;
    xif.rx_reset_req = 1'b0;
    xif.pll_locked = 1'b1;
    xif.tx_cal_busy = tx_cal;
    xif.rx_cal_busy = 1'b0;
    xif.rx_is_lockedtodata = 1'b1;
    tick(2);
    clr_n = 1'b1;
  endtask

  task automatic test_reset;
    restart(1'b0);
    clr_n = 1'b0;
    tick(1);
    total++;
    if (outs !== 7'b1111100) $display("FAIL reset_outs: got %b want %b", outs, 7'b1111100);
    else passed++;
  endtask

  task automatic test_bringup;
    restart(1'b0);
    tick(16);
    total++;
    if (xif.pll_powerdown !== 1'b1) $display("FAIL pd_hold_e16: got %b want 1", xif.pll_powerdown);
    else passed++;
    tick(1);
    total++;
    if ({xif.pll_powerdown, xif.tx_analogreset} !== 2'b01)
      $display("FAIL pd_fall_e17: got %b want 01", {xif.pll_powerdown, xif.tx_analogreset});
    else passed++;
    tick(1);
    total++;
    if ({xif.tx_analogreset, xif.tx_digitalreset, xif.rx_analogreset} !== 3'b011)
      $display("FAIL tx_lock_e18: got %b want 011",
               {xif.tx_analogreset, xif.tx_digitalreset, xif.rx_analogreset});
    else passed++;
    tick(1);
    total++;
    if (xif.rx_analogreset !== 1'b0) $display("FAIL rx_ana_e19: got %b want 0", xif.rx_analogreset);
    else passed++;
    tick(6);
    total++;
    if (xif.tx_ready !== 1'b0) $display("FAIL tx_ready_e25: got %b want 0", xif.tx_ready);
    else passed++;
    tick(1);
    total++;
    if ({xif.tx_ready, xif.tx_digitalreset} !== 2'b10)
      $display("FAIL tx_ready_e26: got %b want 10", {xif.tx_ready, xif.tx_digitalreset});
    else passed++;
    tick(24);
    total++;
    if (xif.rx_ready !== 1'b0) $display("FAIL rx_ready_e50: got %b want 0", xif.rx_ready);
    else passed++;
    tick(1);
    total++;
    if ({xif.rx_ready, xif.rx_digitalreset} !== 2'b10)
      $display("FAIL rx_ready_e51: got %b want 10", {xif.rx_ready, xif.rx_digitalreset});
    else passed++;
  endtask

  task automatic test_cal_stall;
    restart(1'b1);
    tick(116);
    total++;
    if ({xif.pll_powerdown, xif.tx_analogreset, xif.rx_analogreset} !== 3'b011)
      $display("FAIL cal_stall_e116: got %b want 011",
               {xif.pll_powerdown, xif.tx_analogreset, xif.rx_analogreset});
    else passed++;
    xif.tx_cal_busy = 1'b0;
    tick(1);
    total++;
    if (xif.tx_analogreset !== 1'b1) $display("FAIL cal_rel_e117: got %b want 1", xif.tx_analogreset);
    else passed++;
    tick(1);
    total++;
    if ({xif.tx_analogreset, xif.rx_analogreset} !== 2'b01)
      $display("FAIL cal_rel_e118: got %b want 01", {xif.tx_analogreset, xif.rx_analogreset});
    else passed++;
    tick(1);
    total++;
    if (xif.rx_analogreset !== 1'b0) $display("FAIL cal_rx_e119: got %b want 0", xif.rx_analogreset);
    else passed++;
    tick(40);
    total++;
    if ({xif.tx_ready, xif.rx_ready} !== 2'b11)
      $display("FAIL cal_ready: got %b want 11", {xif.tx_ready, xif.rx_ready});
    else passed++;
  endtask

  task automatic test_pll_glitch;
    logic rx_drop;
    rx_drop = 1'b0;
    xif.pll_locked = 1'b0;
    tick(1);
    xif.pll_locked = 1'b1;
    tick(1);
    total++;
    if ({xif.tx_ready, xif.tx_digitalreset} !== 2'b01)
      $display("FAIL glitch_drop: got %b want 01", {xif.tx_ready, xif.tx_digitalreset});
    else passed++;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (xif.rx_ready !== 1'b1) rx_drop = 1'b1;
    end
    total++;
    if (xif.tx_ready !== 1'b0) $display("FAIL glitch_early: got %b want 0", xif.tx_ready);
    else passed++;
    tick(1);
    total++;
    if (xif.tx_ready !== 1'b1) $display("FAIL glitch_back: got %b want 1", xif.tx_ready);
    else passed++;
    total++;
    if (rx_drop !== 1'b0) $display("FAIL glitch_rx: got %b want 0", rx_drop);
    else passed++;
  endtask

  task automatic test_cdr_bounce;
    logic saw_ready;
    saw_ready = 1'b0;
    for (int p = 0; p < 7; p++) begin
      xif.rx_is_lockedtodata = p[0];
      for (int i = 0; i < 5; i++) begin
        tick(1);
        if (!(p == 0 && i == 0) && xif.rx_ready !== 1'b0) saw_ready = 1'b1;
      end
    end
    total++;
    if (saw_ready !== 1'b0) $display("FAIL bounce_ready: got %b want 0", saw_ready);
    else passed++;
    xif.rx_is_lockedtodata = 1'b1;
    tick(32);
    total++;
    if (xif.rx_ready !== 1'b0) $display("FAIL bounce_e32: got %b want 0", xif.rx_ready);
    else passed++;
    tick(1);
    total++;
    if ({xif.rx_ready, xif.tx_ready} !== 2'b11)
      $display("FAIL bounce_e33: got %b want 11", {xif.rx_ready, xif.tx_ready});
    else passed++;
  endtask

  task automatic test_simultaneous;
    xif.pll_locked = 1'b0;
    xif.tx_cal_busy = 1'b1;
    tick(1);
    xif.pll_locked = 1'b1;
    tick(1);
    total++;
    if ({xif.tx_analogreset, xif.tx_ready} !== 2'b10)
      $display("FAIL simul_ana: got %b want 10", {xif.tx_analogreset, xif.tx_ready});
    else passed++;
    xif.tx_cal_busy = 1'b0;
    tick(12);
    total++;
    if (xif.tx_ready !== 1'b1) $display("FAIL simul_recover: got %b want 1", xif.tx_ready);
    else passed++;
  endtask

  task automatic test_restart_priority;
    xif.tx_reset_req = 1'b1;
    xif.pll_locked = 1'b0;
    tick(1);
    total++;
    if (xif.pll_powerdown !== 1'b0) $display("FAIL prio_a: got %b want 0", xif.pll_powerdown);
    else passed++;
    xif.tx_reset_req = 1'b0;
    xif.pll_locked = 1'b1;
    tick(1);
    total++;
    if ({xif.pll_powerdown, xif.tx_analogreset, xif.tx_ready, xif.rx_ready} !== 4'b1100)
      $display("FAIL prio_pd: got %b want 1100",
               {xif.pll_powerdown, xif.tx_analogreset, xif.tx_ready, xif.rx_ready});
    else passed++;
    tick(15);
    total++;
    if (xif.pll_powerdown !== 1'b1) $display("FAIL prio_pd16: got %b want 1", xif.pll_powerdown);
    else passed++;
    tick(1);
    total++;
    if (xif.pll_powerdown !== 1'b0) $display("FAIL prio_pd17: got %b want 0", xif.pll_powerdown);
    else passed++;
    tick(60);
    total++;
    if ({xif.tx_ready, xif.rx_ready} !== 2'b11)
      $display("FAIL prio_ready: got %b want 11", {xif.tx_ready, xif.rx_ready});
    else passed++;
  endtask

  task automatic test_held_req;
    xif.tx_reset_req = 1'b1;
    tick(30);
    xif.tx_reset_req = 1'b0;
    tick(16);
    total++;
    if (xif.pll_powerdown !== 1'b1) $display("FAIL held_pd16: got %b want 1", xif.pll_powerdown);
    else passed++;
    tick(1);
    total++;
    if (xif.pll_powerdown !== 1'b0) $display("FAIL held_pd17: got %b want 0", xif.pll_powerdown);
    else passed++;
    tick(60);
  endtask

  task automatic test_rx_restart;
    xif.rx_reset_req = 1'b1;
    tick(1);
    xif.rx_reset_req = 1'b0;
    tick(1);
    total++;
    if ({xif.rx_ready, xif.rx_analogreset, xif.tx_ready} !== 3'b011)
      $display("FAIL rxreq_a1: got %b want 011",
               {xif.rx_ready, xif.rx_analogreset, xif.tx_ready});
    else passed++;
    tick(32);
    total++;
    if (xif.rx_ready !== 1'b0) $display("FAIL rxreq_a33: got %b want 0", xif.rx_ready);
    else passed++;
    tick(1);
    total++;
    if (xif.rx_ready !== 1'b1) $display("FAIL rxreq_a34: got %b want 1", xif.rx_ready);
    else passed++;
  endtask

  task automatic test_async_reset;
    #2;
    clr_n = 1'b0;
    #1;
    total++;
    if (outs !== 7'b1111100) $display("FAIL async_reset: got %b want %b", outs, 7'b1111100);
    else passed++;
  endtask

`ifdef TSE_XCVR_RST_LOL_CNT_EN
  task automatic test_lol_count;
    restart(1'b0);
    tick(60);
    for (int e = 0; e < 300; e++) begin
      xif.rx_is_lockedtodata = 1'b0;
      tick(1);
      xif.rx_is_lockedtodata = 1'b1;
      tick(32);
    end
    total++;
    if (rx_lol_count !== 8'd255) $display("FAIL lol_sat: got %0d want 255", rx_lol_count);
    else passed++;
    xif.rx_reset_req = 1'b1;
    tick(1);
    xif.rx_reset_req = 1'b0;
    total++;
    if (rx_lol_count !== 8'd0) $display("FAIL lol_clear: got %0d want 0", rx_lol_count);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_bringup();
    test_cal_stall();
    test_pll_glitch();
    test_cdr_bounce();
    test_simultaneous();
    test_restart_priority();
    test_held_req();
    test_rx_restart();
    test_async_reset();
`ifdef TSE_XCVR_RST_LOL_CNT_EN
    test_lol_count();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
